controle_contador: RTL and testbench

CONTROLE_CONTADOR -- requirements
Module: controle_contador

---
 rtl/controle_contador.sv | 167 ++++++++++++++++
 tb/tb_controle_contador.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_contador.sv
// Start/stop, single-step and direction controller driving a counter from three push buttons.
// Defining CONTROLE_DEBOUNCE_EN adds a DEB_CICLOS-cycle stability filter on every button.
module controle_contador #(
  parameter int unsigned LARG_DIV   = 16,
  parameter int unsigned DEB_CICLOS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_iniciar,
  input  logic                btn_passo,
  input  logic                btn_direcao,
  input  logic [LARG_DIV-1:0] divisor,
  output logic                passo,
  output logic                modo,
  output logic                rodando
);

  localparam int unsigned NBTN   = 3;
  // Edge detection stays blind until the synchronizers and filters hold real samples.
  localparam int unsigned WARM   = DEB_CICLOS + 3;
  localparam int unsigned WARM_W = $clog2(WARM + 1);

  typedef enum logic [1:0] {
    PARADO,
    RODANDO,
    PASSO_UNICO
  } estado_t;

  logic [NBTN-1:0]     btn;
  logic [NBTN-1:0]     sync1;
  logic [NBTN-1:0]     sync2;
  logic [NBTN-1:0]     filt;
  logic [NBTN-1:0]     prev;
  logic [NBTN-1:0]     ev;
  logic [WARM_W-1:0]   warm_cnt;
  logic                pronto;
  logic                ev_iniciar;
  logic                ev_passo;
  logic                ev_direcao;

  estado_t             estado;
  estado_t             estado_prox;
  logic [LARG_DIV-1:0] presc;
  logic [LARG_DIV-1:0] presc_prox;
  logic                passo_prox;

  assign btn = {btn_direcao, btn_passo, btn_iniciar};

  // Two-flop synchronizers for the asynchronous buttons.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef CONTROLE_DEBOUNCE_EN
  localparam int unsigned DEB_W = (DEB_CICLOS > 1) ? $clog2(DEB_CICLOS) : 1;

  logic [DEB_W-1:0] deb_cnt [NBTN];

  // Filtered level follows the synchronized level only after DEB_CICLOS stable cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt <= '0;
      for (int unsigned i = 0; i < NBTN; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NBTN; i++) begin
        if (sync2[i] == filt[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_W'(DEB_CICLOS - 1)) begin
          filt[i]    <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end
`else
  assign filt = sync2;
`endif

  // Rising-edge detect; prev is held high during warm-up so a button held through reset is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      warm_cnt <= '0;
      pronto   <= 1'b0;
      prev     <= '1;
    end else begin
      prev <= pronto ? filt : '1;
      if (!pronto) begin
        if (warm_cnt == WARM_W'(WARM)) begin
          pronto <= 1'b1;
        end else begin
          warm_cnt <= warm_cnt + WARM_W'(1);
        end
      end
    end
  end

  assign ev         = filt & ~prev;
  assign ev_iniciar = ev[0];
  assign ev_passo   = ev[1];
  assign ev_direcao = ev[2];

  // State, prescaler and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado  <= PARADO;
      presc   <= '0;
      passo   <= 1'b0;
      rodando <= 1'b0;
      modo    <= 1'b1;
    end else begin
      estado  <= estado_prox;
      presc   <= presc_prox;
      passo   <= passo_prox;
      rodando <= (estado_prox == RODANDO);
      modo    <= modo ^ ev_direcao;
    end
  end

  // Next state; passo_prox is raised on the cycle that enters the step so passo
  // lines up with PASSO_UNICO or with the RODANDO cycle after terminal count.
  always_comb begin
    estado_prox = estado;
    presc_prox  = presc;
    passo_prox  = 1'b0;
    case (estado)
      PARADO: begin
        presc_prox = '0;
        if (ev_iniciar) begin
          estado_prox = RODANDO;
        end else if (ev_passo) begin
          estado_prox = PASSO_UNICO;
          passo_prox  = 1'b1;
        end
      end
      RODANDO: begin
        if (ev_iniciar) begin
          estado_prox = PARADO;
          presc_prox  = '0;
        end else if (presc >= divisor) begin
          passo_prox = 1'b1;
          presc_prox = '0;
        end else begin
          presc_prox = presc + LARG_DIV'(1);
        end
      end
      PASSO_UNICO: begin
        estado_prox = PARADO;
        presc_prox  = '0;
      end
      default: begin
        estado_prox = PARADO;
        presc_prox  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_controle_contador.sv
// Directed bench for controle_contador; build with CONTROLE_DEBOUNCE_EN to exercise the filter.
module tb_controle_contador;

  localparam int unsigned LARG_DIV = 16;
  localparam int unsigned DEB      = 4;
`ifdef CONTROLE_DEBOUNCE_EN
  localparam int FD = 4;
`else
  localparam int FD = 0;
`endif
  // Button rise to state change: 2 sync + filter + 1.
  localparam int LAT  = 3 + FD;
  localparam int HOLD = 6;
  localparam int S    = (4 - ((LAT - 1) % 4)) % 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [2:0]          btn;
  logic [LARG_DIV-1:0] divisor;
  logic                passo;
  logic                modo;
  logic                rodando;

  int n_checks = 0;
  int n_fail   = 0;

  controle_contador #(
    .LARG_DIV  (LARG_DIV),
    .DEB_CICLOS(DEB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_iniciar(btn[0]),
    .btn_passo  (btn[1]),
    .btn_direcao(btn[2]),
    .divisor    (divisor),
    .passo      (passo),
    .modo       (modo),
    .rodando    (rodando)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (12) tick();
  endtask

  task automatic press(input logic [2:0] b);
    btn = b;
    repeat (HOLD) tick();
    btn = '0;
    settle();
  endtask

  task automatic wait_passo(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      tick();
      if (passo === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_passo: no passo within 30 cycles");
    end
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    btn     = '0;
    divisor = '0;
    repeat (2) tick();
    n_checks++;
    if (passo !== 1'b0) begin n_fail++; $display("FAIL reset_passo: got %b expected 0", passo); end
    n_checks++;
    if (modo !== 1'b1) begin n_fail++; $display("FAIL reset_modo: got %b expected 1", modo); end
    n_checks++;
    if (rodando !== 1'b0) begin n_fail++; $display("FAIL reset_rodando: got %b expected 0", rodando); end
    @(negedge clk);
    reset = 1'b1;
    repeat (12) tick();
    n_checks++;
    if (rodando !== 1'b0 || passo !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: rodando=%b passo=%b expected 0 0", rodando, passo);
    end
  endtask

  task automatic test_run();
    logic exp;
    divisor = 16'd3;
    btn     = 3'b001;
    for (int k = 1; k <= LAT + 12; k++) begin
      tick();
      if (k == HOLD) btn = '0;
      if (k == LAT - 1) begin
        n_checks++;
        if (rodando !== 1'b0) begin n_fail++; $display("FAIL run_latency_early: rodando=%b expected 0", rodando); end
      end
      if (k == LAT) begin
        n_checks++;
        if (rodando !== 1'b1) begin n_fail++; $display("FAIL run_latency: rodando=%b expected 1", rodando); end
        n_checks++;
        if (modo !== 1'b1) begin n_fail++; $display("FAIL run_modo: modo=%b expected 1", modo); end
      end
      if (k > LAT) begin
        exp = ((k - LAT) % 4 == 0);
        n_checks++;
        if (passo !== exp) begin
          n_fail++;
          $display("FAIL run_period k=%0d: passo=%b expected %b", k - LAT, passo, exp);
        end
      end
    end
    settle();
  endtask

  task automatic test_direcao();
    bit ok;
    wait_passo(ok);
    if (ok) begin
      repeat (S) tick();
      btn = 3'b100;
      for (int k = 1; k <= HOLD + LAT; k++) begin
        tick();
        if (k == HOLD) btn = '0;
        if (k == LAT - 1) begin
          n_checks++;
          if (passo !== 1'b1) begin n_fail++; $display("FAIL dir_passo_aligned: passo=%b expected 1", passo); end
          n_checks++;
          if (modo !== 1'b1) begin n_fail++; $display("FAIL dir_old_modo: modo=%b expected 1", modo); end
        end
        if (k == LAT) begin
          n_checks++;
          if (modo !== 1'b0) begin n_fail++; $display("FAIL dir_new_modo: modo=%b expected 0", modo); end
        end
      end
    end
    settle();
    btn = 3'b100;
    for (int k = 1; k <= HOLD + LAT; k++) begin
      tick();
      if (k == HOLD) btn = '0;
      if (k == LAT - 1) begin
        n_checks++;
        if (modo !== 1'b0) begin n_fail++; $display("FAIL dir_second_early: modo=%b expected 0", modo); end
      end
      if (k == LAT) begin
        n_checks++;
        if (modo !== 1'b1) begin n_fail++; $display("FAIL dir_restore: modo=%b expected 1", modo); end
      end
    end
    settle();
  endtask

  task automatic test_divisor();
    bit ok;
    int cnt;
    divisor = 16'd10;
    wait_passo(ok);
    if (ok) begin
      cnt = 0;
      repeat (7) begin tick(); if (passo === 1'b1) cnt++; end
      n_checks++;
      if (cnt != 0) begin n_fail++; $display("FAIL div10_quiet: %0d passo expected 0", cnt); end
      divisor = 16'd2;
      tick();
      n_checks++;
      if (passo !== 1'b1) begin n_fail++; $display("FAIL div_lowered_fire: passo=%b expected 1", passo); end
      cnt = 0;
      repeat (2) begin tick(); if (passo === 1'b1) cnt++; end
      n_checks++;
      if (cnt != 0) begin n_fail++; $display("FAIL div2_gap: %0d passo expected 0", cnt); end
      tick();
      n_checks++;
      if (passo !== 1'b1) begin n_fail++; $display("FAIL div2_period: passo=%b expected 1", passo); end
      divisor = 16'd0;
      cnt = 0;
      repeat (5) begin tick(); if (passo === 1'b1) cnt++; end
      n_checks++;
      if (cnt != 5) begin n_fail++; $display("FAIL div0_every_cycle: %0d passo expected 5", cnt); end
    end
  endtask

  task automatic test_stop();
    int cnt = 0;
    btn = 3'b001;
    for (int k = 1; k <= LAT + 50; k++) begin
      tick();
      if (k == HOLD) btn = '0;
      if (k == LAT - 1) begin
        n_checks++;
        if (rodando !== 1'b1 || passo !== 1'b1) begin
          n_fail++;
          $display("FAIL stop_pre: rodando=%b passo=%b expected 1 1", rodando, passo);
        end
      end
      if (k == LAT) begin
        n_checks++;
        if (rodando !== 1'b0) begin n_fail++; $display("FAIL stop_rodando: rodando=%b expected 0", rodando); end
      end
      if (k >= LAT && passo === 1'b1) cnt++;
    end
    n_checks++;
    if (cnt != 0) begin n_fail++; $display("FAIL stop_no_passo: %0d passo expected 0", cnt); end
    settle();
  endtask

  task automatic test_step();
    int cnt = 0;
    btn = 3'b010;
    for (int k = 1; k <= LAT + 10; k++) begin
      tick();
      if (k == HOLD) btn = '0;
      if (passo === 1'b1) cnt++;
      if (k == LAT) begin
        n_checks++;
        if (passo !== 1'b1) begin n_fail++; $display("FAIL step_pulse: passo=%b expected 1", passo); end
      end
    end
    n_checks++;
    if (cnt != 1) begin n_fail++; $display("FAIL step_single: %0d passo expected 1", cnt); end
    n_checks++;
    if (rodando !== 1'b0) begin n_fail++; $display("FAIL step_back_parado: rodando=%b expected 0", rodando); end
    settle();
  endtask

  task automatic test_simultaneous();
    int cnt = 0;
    divisor = 16'd10;
    btn     = 3'b011;
    for (int k = 1; k <= LAT + 8; k++) begin
      tick();
      if (k == HOLD) btn = '0;
      if (passo === 1'b1) cnt++;
      if (k == LAT) begin
        n_checks++;
        if (rodando !== 1'b1) begin n_fail++; $display("FAIL simul_rodando: rodando=%b expected 1", rodando); end
      end
    end
    n_checks++;
    if (cnt != 0) begin n_fail++; $display("FAIL simul_no_single_step: %0d passo expected 0", cnt); end
    settle();
    press(3'b001);
    n_checks++;
    if (rodando !== 1'b0) begin n_fail++; $display("FAIL simul_stopped: rodando=%b expected 0", rodando); end
  endtask

  task automatic test_debounce();
    int cnt = 0;
`ifdef CONTROLE_DEBOUNCE_EN
    btn = 3'b010;
    repeat (3) tick();
    btn = '0;
    repeat (20) begin tick(); if (passo === 1'b1) cnt++; end
    n_checks++;
    if (cnt != 0) begin n_fail++; $display("FAIL deb_glitch: %0d passo expected 0", cnt); end
    cnt = 0;
    btn = 3'b010;
    repeat (6) begin tick(); if (passo === 1'b1) cnt++; end
    btn = '0;
    repeat (20) begin tick(); if (passo === 1'b1) cnt++; end
    n_checks++;
    if (cnt != 1) begin n_fail++; $display("FAIL deb_press: %0d passo expected 1", cnt); end
`else
    btn = 3'b010;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) btn = '0;
      if (passo === 1'b1) cnt++;
      if (k == 3) begin
        n_checks++;
        if (passo !== 1'b1) begin n_fail++; $display("FAIL nodeb_pulse: passo=%b expected 1", passo); end
      end
    end
    n_checks++;
    if (cnt != 1) begin n_fail++; $display("FAIL nodeb_count: %0d passo expected 1", cnt); end
`endif
    settle();
  endtask

  task automatic test_reset_mid();
    int cnt  = 0;
    int rcnt = 0;
    divisor = 16'd0;
    press(3'b001);
    press(3'b100);
    n_checks++;
    if (rodando !== 1'b1 || modo !== 1'b0 || passo !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: rodando=%b modo=%b passo=%b expected 1 0 1", rodando, modo, passo);
    end
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    n_checks++;
    if (passo !== 1'b0) begin n_fail++; $display("FAIL mid_reset_passo: passo=%b expected 0", passo); end
    n_checks++;
    if (rodando !== 1'b0) begin n_fail++; $display("FAIL mid_reset_rodando: rodando=%b expected 0", rodando); end
    n_checks++;
    if (modo !== 1'b1) begin n_fail++; $display("FAIL mid_reset_modo: modo=%b expected 1", modo); end
    btn = 3'b001;
    @(negedge clk);
    reset = 1'b1;
    repeat (20) begin
      tick();
      if (passo === 1'b1) cnt++;
      if (rodando === 1'b1) rcnt++;
    end
    n_checks++;
    if (cnt != 0) begin n_fail++; $display("FAIL post_reset_passo: %0d passo expected 0", cnt); end
    n_checks++;
    if (rcnt != 0) begin n_fail++; $display("FAIL held_button_event: rodando high %0d cycles expected 0", rcnt); end
    btn = '0;
    settle();
    btn = 3'b001;
    for (int k = 1; k <= HOLD + LAT; k++) begin
      tick();
      if (k == HOLD) btn = '0;
      if (k == LAT) begin
        n_checks++;
        if (rodando !== 1'b1) begin n_fail++; $display("FAIL repress_after_reset: rodando=%b expected 1", rodando); end
      end
    end
    settle();
    press(3'b001);
  endtask

  initial begin
    reset   = 1'b0;
    btn     = '0;
    divisor = '0;
    test_reset();
    test_run();
    test_direcao();
    test_divisor();
    test_stop();
    test_step();
    test_simultaneous();
    test_debounce();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
